// File: rtl/fifo_word_packer.sv
// Packs pairs of first-word-fall-through FIFO words into double-width words.
// A lone held word is flushed as a half-valid word after an idle timeout.
module fifo_word_packer #(
    parameter int IN_WIDTH      = 32,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [2*IN_WIDTH-1:0] out_data,
    output logic [1:0]            out_mask,
    output logic                  out_wr,
    input  logic                  out_rdy
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT = FLUSH_TIMEOUT[7:0];

    state_t                state_q;
    logic [IN_WIDTH-1:0]   hold_q;
    logic [7:0]            idle_cnt_q;
    logic [2*IN_WIDTH-1:0] out_data_q;
    logic [1:0]            out_mask_q;
    logic                  out_wr_q;

    logic pop;
    logic flush;

    // Never pop while a half is held and downstream cannot take the pair.
    assign pop   = !reset && !in_empty &&
                   (state_q == EMPTY || out_rdy);
    assign flush = (state_q == HALF) && in_empty && out_rdy &&
                   (idle_cnt_q == TIMEOUT);

    assign in_rd_en = pop;
    assign out_data = out_data_q;
    assign out_mask = out_mask_q;
    assign out_wr   = out_wr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            hold_q     <= '0;
            idle_cnt_q <= '0;
            out_data_q <= '0;
            out_mask_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            out_wr_q <= 1'b0;
            unique case (state_q)
                EMPTY: begin
                    if (pop) begin
                        hold_q     <= in_data;
                        idle_cnt_q <= '0;
                        state_q    <= HALF;
                    end
                end
                HALF: begin
                    if (pop) begin
                        out_data_q <= {in_data, hold_q};
                        out_mask_q <= 2'b11;
                        out_wr_q   <= 1'b1;
                        state_q    <= EMPTY;
                    end else if (flush) begin
                        out_data_q <= {{IN_WIDTH{1'b0}}, hold_q};
                        out_mask_q <= 2'b01;
                        out_wr_q   <= 1'b1;
                        state_q    <= EMPTY;
                    end else if (idle_cnt_q < TIMEOUT) begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-backed FIFO, behavioural packer model,
// directed scenarios with literal expectations and a randomized soak.
module tb_fifo_word_packer;

    localparam int W  = 32;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in_data;
    logic           in_empty;
    logic           in_rd_en;
    logic [2*W-1:0] out_data;
    logic [1:0]     out_mask;
    logic           out_wr;
    logic           out_rdy;

    always #5 clk = ~clk;

    fifo_word_packer #(
        .IN_WIDTH     (W),
        .FLUSH_TIMEOUT(TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .out_data(out_data),
        .out_mask(out_mask),
        .out_wr  (out_wr),
        .out_rdy (out_rdy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [W-1:0] fifo[$];

    // model: words currently held, idle count and registered outputs
    logic [W-1:0]   held[$];
    int             idle = 0;
    logic           exp_wr;
    logic [2*W-1:0] exp_data;
    logic [1:0]     exp_mask;
    bit             armed = 1'b0;

    logic           s_rd, s_empty, s_rdy, s_reset;
    logic [W-1:0]   s_data;

    logic [2*W+1:0] log_q[$];
    int             wcyc[$];
    int             pop_cyc[int];
    logic [2*W+1:0] exp_log[$];

    function automatic void drive();
        in_empty = (fifo.size() == 0);
        in_data  = in_empty ? '0 : fifo[0];
    endfunction

    function automatic logic [2*W+1:0] pk(input logic [1:0] m,
                                          input logic [W-1:0] hi,
                                          input logic [W-1:0] lo);
        return {m, hi, lo};
    endfunction

    task automatic check1(input string name, input logic [2*W+1:0] act,
                          input logic [2*W+1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_log(input string name);
        check1({name, "_count"}, log_q.size(), exp_log.size());
        foreach (exp_log[i]) begin
            if (i < log_q.size())
                check1(name, log_q[i], exp_log[i]);
            else
                check1(name, 'x, exp_log[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_q.delete();
        wcyc.delete();
        exp_log.delete();
    endtask

    // compare process: outputs are stable mid-cycle
    always @(negedge clk) begin
        if (reset === 1'b1)
            check1("rst_rd_en", in_rd_en, 1'b0);
        if (armed) begin
            check1("rd_en", in_rd_en,
                   !reset && !in_empty && (held.size() == 0 || out_rdy));
            check1("out_wr", out_wr, exp_wr);
            check1("out_data", out_data, exp_data);
            check1("out_mask", out_mask, exp_mask);
        end
        if (out_wr === 1'b1) begin
            log_q.push_back({out_mask, out_data});
            wcyc.push_back(cyc);
        end
        if (in_rd_en === 1'b1)
            pop_cyc[int'(in_data)] = cyc;
        s_rd    = in_rd_en;
        s_data  = in_data;
        s_empty = in_empty;
        s_rdy   = out_rdy;
        s_reset = reset;
        cyc++;
    end

    // model step and FIFO pop, just after each rising edge
    always @(posedge clk) begin
        #1;
        if (s_reset === 1'b1) begin
            armed    = 1'b1;
            held.delete();
            idle     = 0;
            exp_wr   = 1'b0;
            exp_data = '0;
            exp_mask = '0;
        end else if (armed) begin
            exp_wr = 1'b0;
            if (held.size() == 0) begin
                if (s_rd === 1'b1) begin
                    held.push_back(s_data);
                    idle = 0;
                end
            end else if (s_rd === 1'b1) begin
                exp_data = {s_data, held[0]};
                exp_mask = 2'b11;
                exp_wr   = 1'b1;
                held.delete();
            end else if (s_empty && s_rdy && idle == TO) begin
                exp_data = {{W{1'b0}}, held[0]};
                exp_mask = 2'b01;
                exp_wr   = 1'b1;
                held.delete();
            end else if (idle < TO) begin
                idle++;
            end
        end
        if (s_rd === 1'b1 && fifo.size() != 0)
            void'(fifo.pop_front());
        drive();
    end

    initial begin
        reset   = 1'b1;
        out_rdy = 1'b1;
        fifo.push_back(32'd11);
        fifo.push_back(32'd12);
        drive();

        // reset with a non-empty FIFO
        repeat (2) tick();
        check1("rst_out_wr", out_wr, 1'b0);
        check1("rst_out_data", out_data, '0);
        check1("rst_out_mask", out_mask, '0);
        fifo.delete();
        drive();
        reset = 1'b0;
        repeat (4) tick();

        // streaming 1..8
        clear_log();
        for (int i = 1; i <= 8; i++) fifo.push_back(W'(i));
        drive();
        repeat (16) tick();
        for (int i = 0; i < 4; i++)
            exp_log.push_back(pk(2'b11, W'(2*i+2), W'(2*i+1)));
        check_log("stream");
        if (wcyc.size() >= 4) begin
            check1("stream_lat", wcyc[0] - pop_cyc[1], 2);
            for (int i = 1; i < 4; i++)
                check1("stream_gap", wcyc[i] - wcyc[i-1], 2);
        end else begin
            check1("stream_writes", wcyc.size(), 4);
        end

        // odd count flush
        clear_log();
        for (int i = 1; i <= 3; i++) fifo.push_back(W'(i));
        drive();
        repeat (16) tick();
        exp_log.push_back(pk(2'b11, W'(2), W'(1)));
        exp_log.push_back(pk(2'b01, W'(0), W'(3)));
        check_log("odd");
        if (wcyc.size() >= 2)
            check1("flush_lat", wcyc[1] - pop_cyc[3], 6);
        else
            check1("odd_writes", wcyc.size(), 2);

        // timeout race: word 10 readable when idle count reaches 4
        clear_log();
        fifo.push_back(W'(9));
        drive();
        repeat (5) tick();
        fifo.push_back(W'(10));
        drive();
        repeat (12) tick();
        exp_log.push_back(pk(2'b11, W'(10), W'(9)));
        check_log("race");
        check1("race_gap", pop_cyc[10] - pop_cyc[9], 5);

        // backpressure
        clear_log();
        for (int i = 1; i <= 8; i++) fifo.push_back(W'(i));
        drive();
        for (int c = 0; c < 60; c++) begin
            out_rdy = ((c / 3) % 2) == 0;
            tick();
        end
        out_rdy = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 4; i++)
            exp_log.push_back(pk(2'b11, W'(2*i+2), W'(2*i+1)));
        check_log("bp");

        // reset mid-operation
        clear_log();
        fifo.push_back(W'(5));
        drive();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fifo.push_back(W'(6));
        fifo.push_back(W'(7));
        drive();
        repeat (12) tick();
        exp_log.push_back(pk(2'b11, W'(7), W'(6)));
        check_log("midrst");

        // randomized soak against the model
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase = (i / 100) % 3;
            if ($urandom_range(99) < (phase == 0 ? 70 : phase == 1 ? 30 : 4))
                fifo.push_back($urandom);
            out_rdy = ($urandom_range(3) != 0);
            reset   = ($urandom_range(199) == 0);
            drive();
            tick();
        end
        reset   = 1'b0;
        out_rdy = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of a `fallthrough_small_fifo`.
- Drains `IN_WIDTH`-bit words from the FIFO's first-word-fall-through read port.
- Packs pairs of words into `2*IN_WIDTH`-bit output words for the wider datapath stage that follows.
- Tags each output with a half-valid mask.
- Flushes a lone held word after a programmable idle timeout, so trailing data is never stranded.

## Interface
Parameters:
- `IN_WIDTH`, 32: width of one FIFO word.
- `FLUSH_TIMEOUT`, 16: idle cycles a held half-word waits before a partial flush. Legal range 1..255. The counter is 8 bits.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  `IN_WIDTH`: FIFO `dout`; valid whenever `in_empty`=0.
- `in_empty`  in  1: FIFO `empty`.
- `in_rd_en`  out  1: FIFO `rd_en`; combinational pop strobe.
- `out_data`  out  `2*IN_WIDTH`: packed word. First-read word in `[IN_WIDTH-1:0]`, second in `[2*IN_WIDTH-1:IN_WIDTH]`.
- `out_mask`  out  2: bit0 = low half valid, bit1 = high half valid.
- `out_wr`  out  1: one-cycle write strobe qualifying `out_data`/`out_mask`.
- `out_rdy`  in  1: downstream can accept at least one more word (for example, inverted `nearly_full`).

## Operation
- State machine: `EMPTY` (no half held) and `HALF` (low half held in `hold_reg`).
- `in_rd_en = !reset && !in_empty && (state==EMPTY || (state==HALF && out_rdy))`.
- `EMPTY`:
  - If `in_rd_en`: `hold_reg <= in_data`, `idle_cnt <= 0`, go to `HALF`.
  - Otherwise stay.
- `HALF`, checked in priority order:
  1. **Pair:** if `in_rd_en`, register `out_data <= {in_data, hold_reg}`, `out_mask <= 2'b11`, `out_wr <= 1`, go to `EMPTY`.
  2. **Flush:** else if `in_empty && out_rdy && idle_cnt==FLUSH_TIMEOUT`, register `out_data <= {0, hold_reg}`, `out_mask <= 2'b01`, `out_wr <= 1`, go to `EMPTY`.
  3. **Idle:** else if `idle_cnt < FLUSH_TIMEOUT`, increment `idle_cnt`. It saturates at `FLUSH_TIMEOUT` while `out_rdy`=0.
- Pairing beats flushing in the same cycle: data arriving at the timeout cycle is packed, never split.
- `out_wr` defaults to 0 every cycle unless set by a pair or flush.
  - Consequence: `out_wr` is never high in two consecutive cycles.
  - `out_data`/`out_mask` hold their last value between strobes.
- The block never pops the FIFO while holding a half with `out_rdy`=0. Backpressure therefore propagates to the FIFO with no data loss.
- Reset mid-operation: the held half-word is discarded, no `out_wr` is generated, and state returns to `EMPTY`.

## Timing
- Reset values:
  - `out_wr`=0, `out_data`=0, `out_mask`=0.
  - `in_rd_en`=0 for every cycle `reset` is high.
  - state `EMPTY`, `idle_cnt`=0, `hold_reg`=0.
- Pair latency: pops in cycles n and n+1 (with `out_rdy`=1 in n+1) give `out_wr`=1 in cycle n+2.
- Sustained throughput: 1 input word per cycle and 1 output word per 2 cycles; `in_rd_en` is continuously high.
- Flush latency:
  - Lone pop in cycle 0, then `in_empty`=1 and `out_rdy`=1: `out_wr`=1 with mask `01` in cycle `FLUSH_TIMEOUT+2`.
  - With `out_rdy` low at the timeout, the flush fires the cycle after `out_rdy` returns, if the FIFO is still empty.
- `out_rdy` is sampled only in the cycle a pair or flush is decided. The write strobe lands one cycle later.

## Test plan
Config: `IN_WIDTH`=32, `FLUSH_TIMEOUT`=4.

1. **Reset:** hold `reset` 2 cycles with the FIFO non-empty → `in_rd_en`=0 and `out_wr`=0 throughout; all outputs 0.
2. **Streaming:** FIFO preloaded 1..8, `out_rdy`=1 → 4 strobes on alternating cycles, `out_data` = `{2,1},{4,3},{6,5},{8,7}`, mask `11`; first strobe 2 cycles after the first pop.
3. **Odd count flush:** write 1..3 → `{2,1}` mask `11`, then `{0,3}` mask `01` exactly 6 cycles after word 3 is popped.
4. **Timeout race:** pop word 9; make word 10 readable in exactly the cycle `idle_cnt`==4 → single `{10,9}` mask `11`, no partial flush.
5. **Backpressure:** stream 1..8 with `out_rdy` toggling every 3 cycles → no pop while `HALF` and `out_rdy`=0; output sequence identical to scenario 2, with no lost or duplicated words.
6. **Reset mid-operation:** pop word 5 (state `HALF`), assert `reset` 1 cycle, then supply 6,7 → word 5 dropped; only `{7,6}` emitted.
